// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg                                                              |
// | Shared AES types and constants for the key schedule and round logic. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_NR = 14;
  localparam int AES_NK = 8;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] round_key_t;

  // Round constants for the even (rotating) schedule steps.
  localparam logic [7:0] AES_RCON [0:6] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_sbox                                                             |
// | Combinational AES forward S-box, one byte in, one byte out.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0x00 sits at the top byte; ~in_byte turns the address into a
  // little-endian byte offset into the packed table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/aes256_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes256_key_expand                                                    |
// | Iterative AES-256 key schedule: one 128-bit round key per cycle into |
// | an indexed key store read by the round controller.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes256_key_expand
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [255:0]     key_in,
  input  logic [IDX_W-1:0] rk_rd_idx,
  output logic [127:0]     rk_rd_data,
  output logic             keys_valid,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NR);
  localparam logic [IDX_W-1:0] FIRST_EXP = IDX_W'(2);

  ks_state_e        state;
  ks_state_e        state_next;
  logic [IDX_W-1:0] cnt;
  round_key_t       store [0:NR];
  logic             accept;

  round_key_t       prev2;
  aes_word_t        prev1_low;
  aes_word_t        t_rot;
  aes_word_t        t_sub;
  aes_word_t        t_mix;
  aes_word_t        w0;
  aes_word_t        w1;
  aes_word_t        w2;
  aes_word_t        w3;
  logic             even_step;
  logic [2:0]       rcon_idx;
  logic [7:0]       rcon;

  assign accept = key_valid && key_ready;

  // Schedule step: RK[cnt] is built from the two previous round keys.
  // Even steps rotate and add Rcon; odd steps only substitute.
  assign prev2     = store[cnt - FIRST_EXP];
  assign prev1_low = store[cnt - IDX_W'(1)][31:0];
  assign even_step = ~cnt[0];
  assign rcon_idx  = cnt[3:1] - 3'd1;
  assign rcon      = (rcon_idx <= 3'd6) ? AES_RCON[rcon_idx] : 8'h00;
  assign t_rot     = even_step ? {prev1_low[23:0], prev1_low[31:24]} : prev1_low;
  assign t_mix     = t_sub ^ (even_step ? {rcon, 24'h0} : 32'h0);
  assign w0        = prev2[127:96] ^ t_mix;
  assign w1        = prev2[95:64]  ^ w0;
  assign w2        = prev2[63:32]  ^ w1;
  assign w3        = prev2[31:0]   ^ w2;

  generate
    for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (t_rot[8*b +: 8]),
        .out_byte (t_sub[8*b +: 8])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a new key can start from IDLE or DONE; EXPAND ends on RK[NR].
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_EXPAND;
      ST_EXPAND: if (cnt == LAST_IDX) state_next = ST_DONE;
      ST_DONE:   if (accept) state_next = ST_EXPAND;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    key_ready  = 1'b0;
    busy       = 1'b0;
    keys_valid = 1'b0;
    case (state)
      ST_IDLE:   key_ready = 1'b1;
      ST_EXPAND: busy      = 1'b1;
      ST_DONE: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
      end
      default:   key_ready = 1'b0;
    endcase
  end

  // Key store and step counter; reset wipes every stored round key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i <= NR; i++) begin
        store[i] <= '0;
      end
    end else if (accept) begin
      store[0] <= key_in[255:128];
      store[1] <= key_in[127:0];
      cnt      <= FIRST_EXP;
    end else if (state == ST_EXPAND) begin
      store[cnt] <= {w0, w1, w2, w3};
      cnt        <= cnt + IDX_W'(1);
    end
  end

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_rd_data <= '0;
    end else if (rk_rd_idx <= LAST_IDX) begin
      rk_rd_data <= store[rk_rd_idx];
    end else begin
      rk_rd_data <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes256_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes256_key_expand                                                 |
// | Scoreboard bench with a word-level FIPS-197 key schedule reference.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [255:0] key_in = '0;
  logic [3:0]   rk_rd_idx = '0;
  logic [127:0] rk_rd_data;
  logic         keys_valid;
  logic         busy;

  always #5 clk = ~clk;

  aes256_key_expand #(.NR(14), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    int           due;
    bit           ready;
    bit           bsy;
    bit           valid;
    bit           chk;
    logic [127:0] data;
    int           idx;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0]   sbox_ref [256];
  logic [127:0] m_keys [15];
  int           m_left = 0;
  bit           m_valid = 0;
  bit           m_zero = 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] xb = 8'(x);
      for (int y = 1; y < 256; y++) begin
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  // FIPS-197 word recurrence over w[0..59].
  task automatic expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        rc = 8'h01 << (i/8 - 1);
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) m_keys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle of inputs, predict the outputs seen after the next edge.
  task automatic step(input bit kv, input logic [255:0] k, input int idx,
                      input bit use_c = 0, input logic [127:0] cval = '0);
    exp_t e;
    bit   acc;
    key_valid = kv;
    key_in    = k;
    rk_rd_idx = 4'(idx);
    e.due = cyc + 1;
    e.idx = idx;
    if (!rst_n) begin
      e.ready = 1; e.bsy = 0; e.valid = 0; e.chk = 1; e.data = '0;
    end else begin
      e.chk  = m_valid || m_zero;
      e.data = (m_zero || idx > 14) ? '0 : m_keys[idx];
      acc = kv && (m_left == 0);
      if (acc) begin
        expand(k);
        m_left = 13; m_valid = 0; m_zero = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_valid = 1;
      end
      e.ready = (m_left == 0);
      e.bsy   = (m_left > 0);
      e.valid = m_valid;
    end
    if (use_c) begin
      e.chk = 1; e.data = cval;
    end
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, $urandom_range(0, 15));
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) step(0, '0, i);
  endtask

  task automatic rd(input int idx, input logic [127:0] v);
    step(0, '0, idx, 1, v);
  endtask

  // Reset asserted mid-cycle; effect must be immediate.
  task automatic do_reset(input int hold);
    @(negedge clk); #1;
    rst_n = 0;
    m_left = 0; m_valid = 0; m_zero = 1;
    #1;
    check("rst_key_ready", 128'(key_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_keys_valid", 128'(keys_valid), 128'(0));
    check("rst_rd_data", rk_rd_data, '0);
    @(posedge clk); #1;
    idle(hold);
    rst_n = 1;
  endtask

  // Monitor: compare every due scoreboard entry on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      me = sb.pop_front();
      check("key_ready", 128'(key_ready), 128'(me.ready));
      check("busy", 128'(busy), 128'(me.bsy));
      check("keys_valid", 128'(keys_valid), 128'(me.valid));
      if (me.chk) check($sformatf("rd_data[%0d]", me.idx), rk_rd_data, me.data);
    end
  end

  initial begin
    logic [255:0] rk;
    int guard;
    build_sbox();

    do_reset(2);
    idle(2);

    // C.3 vector
    step(1, KEY_C3, 0);
    idle(13);
    rd(2,  128'ha573c29fa176c498a97fce93a572c09c);
    rd(3,  128'h1651a8cd0244beda1a5da4c10640bade);
    rd(14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    sweep();

    // A.3 vector, restarting from DONE
    step(1, KEY_A3, 5);
    idle(13);
    rd(0,  128'h603deb1015ca71be2b73aef0857d7781);
    rd(14, 128'hfe4890d1e6188d0b046df344706c631e);
    rd(15, 128'h0);
    sweep();

    // Second key held from A+5 until the block takes it
    step(1, KEY_C3, 1);
    idle(4);
    guard = 0;
    while (guard < 20) begin
      bit will_accept;
      will_accept = (m_left == 0);
      step(1, KEY_A3, $urandom_range(0, 15));
      guard++;
      if (will_accept) break;
    end
    if (guard >= 20) check("handshake_accept_bound", 128'(guard), 128'(0));
    idle(13);
    rd(0,  128'h603deb1015ca71be2b73aef0857d7781);
    rd(14, 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset in the middle of expansion, then re-accept
    step(1, KEY_A3, 2);
    idle(5);
    do_reset(2);
    idle(3);
    step(1, KEY_C3, 14);
    idle(13);
    rd(14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    sweep();

    // Random keys with junk key_valid pulses during expansion
    repeat (3) begin
      for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
      step(1, rk, $urandom_range(0, 15));
      for (int j = 0; j < 12; j++) step(1'($urandom_range(0, 1)), ~rk, $urandom_range(0, 15));
      step(0, '0, 0);
      sweep();
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) check("scoreboard_drain", 128'(sb.size()), 128'(0));
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
